// File: rtl/idli_pkg.sv
// Shared types and SRAM command constants for the idli SQI memory path.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        SQI_INIT,
        SQI_IDLE,
        SQI_CMD,
        SQI_ADDR,
        SQI_DUMMY,
        SQI_DATA,
        SQI_END
    } sqi_state_t;

    localparam logic [7:0] SQI_CMD_RD   = 8'h03;
    localparam logic [7:0] SQI_CMD_WR   = 8'h02;
    localparam logic [7:0] SQI_CMD_EQIO = 8'h38;

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM initiator: command/address/dummy/data sequencing with redirect support.
// Define IDLI_SQI_INIT_EN to send EQIO after reset and switch the SRAM to quad mode.
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CS_GAP = 1,
    parameter logic [7:0]  CMD_RD = SQI_CMD_RD,
    parameter logic [7:0]  CMD_WR = SQI_CMD_WR
) (
    input  logic              i_sqi_gck,
    input  logic              i_sqi_rst_n,
    input  logic              i_sqi_req,
    input  logic              i_sqi_wr,
    input  logic [ADDR_W-1:0] i_sqi_addr,
    input  logic              i_sqi_end,
    output logic              o_sqi_req_rdy,
    output sqi_data_t         o_sqi_rd_data,
    output logic              o_sqi_rd_vld,
    input  sqi_data_t         i_sqi_wr_data,
    input  logic              i_sqi_wr_vld,
    output logic              o_sqi_wr_rdy,
    output logic              o_sqi_cs_n,
    output logic              o_sqi_sck_en,
    output logic [3:0]        o_sqi_sio,
    output logic [3:0]        o_sqi_sio_en,
    input  logic [3:0]        i_sqi_sio
);

    localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

`ifdef IDLI_SQI_INIT_EN
    localparam sqi_state_t RST_STATE   = SQI_INIT;
    localparam logic       RST_REQ_RDY = 1'b0;
`else
    localparam sqi_state_t RST_STATE   = SQI_IDLE;
    localparam logic       RST_REQ_RDY = 1'b1;
`endif

    sqi_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              redir_q, redir_d;
    logic              cs_n_q, cs_n_d;
    logic              sck_en_q, sck_en_d;
    logic [3:0]        sio_q, sio_d;
    logic [3:0]        sio_en_q, sio_en_d;
    logic              req_rdy_q, req_rdy_d;
    logic              wr_rdy_q, wr_rdy_d;
    logic              consume;
    logic [7:0]        cmd;
    logic [23:0]       baddr;

    // Outputs are computed from the next state so they line up with state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        redir_d = redir_q;
        consume = (state_q == SQI_DATA) && wr_q && i_sqi_wr_vld && !i_sqi_req && !i_sqi_end;

        case (state_q)
`ifdef IDLI_SQI_INIT_EN
            SQI_INIT: begin
                // cs_n still high marks the pre-start cycle right after reset
                if (cs_n_q) begin
                    cnt_d = '0;
                end else if (cnt_q == 3'd7) begin
                    state_d = SQI_END;
                    gap_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`endif
            SQI_IDLE: begin
                if (i_sqi_req && req_rdy_q) begin
                    wr_d    = i_sqi_wr;
                    addr_d  = i_sqi_addr;
                    state_d = SQI_CMD;
                    cnt_d   = '0;
                end
            end
            SQI_CMD: begin
                if (cnt_q == 3'd1) begin
                    state_d = SQI_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SQI_ADDR: begin
                if (cnt_q == 3'd5) begin
                    state_d = wr_q ? SQI_DATA : SQI_DUMMY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SQI_DUMMY: begin
                if (cnt_q == 3'd1) begin
                    state_d = SQI_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SQI_DATA: begin
                if (i_sqi_req) begin
                    wr_d    = i_sqi_wr;
                    addr_d  = i_sqi_addr;
                    redir_d = 1'b1;
                    state_d = SQI_END;
                    gap_d   = '0;
                end else if (i_sqi_end) begin
                    state_d = SQI_END;
                    gap_d   = '0;
                end
            end
            SQI_END: begin
                if (gap_q == GAP_LAST) begin
                    state_d = redir_q ? SQI_CMD : SQI_IDLE;
                    cnt_d   = '0;
                    redir_d = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = SQI_IDLE;
        endcase

        cmd             = wr_d ? CMD_WR : CMD_RD;
        baddr           = '0;
        baddr[ADDR_W:1] = addr_d;

        cs_n_d    = 1'b1;
        sck_en_d  = 1'b0;
        sio_d     = '0;
        sio_en_d  = '0;
        req_rdy_d = 1'b0;
        wr_rdy_d  = 1'b0;

        case (state_d)
`ifdef IDLI_SQI_INIT_EN
            SQI_INIT: begin
                cs_n_d   = 1'b0;
                sck_en_d = 1'b1;
                sio_d    = {3'b000, SQI_CMD_EQIO[3'd7 - cnt_d]};
                sio_en_d = 4'b0001;
            end
`endif
            SQI_IDLE: req_rdy_d = 1'b1;
            SQI_CMD: begin
                cs_n_d   = 1'b0;
                sck_en_d = 1'b1;
                sio_d    = cnt_d[0] ? cmd[3:0] : cmd[7:4];
                sio_en_d = 4'hF;
            end
            SQI_ADDR: begin
                cs_n_d   = 1'b0;
                sck_en_d = 1'b1;
                sio_d    = baddr[5'd20 - {cnt_d, 2'b00} +: 4];
                sio_en_d = 4'hF;
            end
            SQI_DUMMY: begin
                cs_n_d   = 1'b0;
                sck_en_d = 1'b1;
            end
            SQI_DATA: begin
                cs_n_d    = 1'b0;
                req_rdy_d = 1'b1;
                if (wr_d) begin
                    // A nibble accepted this cycle goes out on the bus next cycle.
                    wr_rdy_d = 1'b1;
                    sio_en_d = 4'hF;
                    sck_en_d = consume;
                    sio_d    = consume ? i_sqi_wr_data : sio_q;
                end else begin
                    sck_en_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            gap_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            redir_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_en_q  <= 1'b0;
            sio_q     <= '0;
            sio_en_q  <= '0;
            req_rdy_q <= RST_REQ_RDY;
            wr_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            redir_q   <= redir_d;
            cs_n_q    <= cs_n_d;
            sck_en_q  <= sck_en_d;
            sio_q     <= sio_d;
            sio_en_q  <= sio_en_d;
            req_rdy_q <= req_rdy_d;
            wr_rdy_q  <= wr_rdy_d;
        end
    end

    assign o_sqi_rd_data = i_sqi_sio;
    assign o_sqi_rd_vld  = (state_q == SQI_DATA) && !wr_q && !i_sqi_req && !i_sqi_end;
    assign o_sqi_req_rdy = req_rdy_q;
    assign o_sqi_wr_rdy  = wr_rdy_q;
    assign o_sqi_cs_n    = cs_n_q;
    assign o_sqi_sck_en  = sck_en_q;
    assign o_sqi_sio     = sio_q;
    assign o_sqi_sio_en  = sio_en_q;

endmodule
